// File: rtl/serial_pkg.sv
// Shared framing definitions for the serial link.
// Transmitter and receiver both import these defaults.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

endpackage

// File: rtl/baud_tick.sv
// Bit-period divider for the serial transmitter.
// Pulses bit_end on the last clock of each serial bit.
module baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Clearing on frame start aligns the first bit period to the handshake.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start, data LSB-first,
// optional parity, stop. All outputs are registered.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);

    tx_state_t         state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [BW-1:0]     bitcnt, bitcnt_n;
    logic              par, par_n;
    logic              tx_n, done_n;
    logic              hs, bit_end, tick_en;

    assign hs      = (state == IDLE) && in_valid && in_ready;
    assign tick_en = (state != IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (hs),
        .en     (tick_en),
        .bit_end(bit_end)
    );

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        par_n    = par;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    state_n = START;
                    shreg_n = in_data;
                    par_n   = (^in_data) ^ 1'(PARITY_ODD);
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bitcnt == BLAST) begin
                        bitcnt_n = '0;
                        state_n  = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line level is derived from the next state so tx stays registered.
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bitcnt   <= bitcnt_n;
            par      <= par_n;
            tx       <= tx_n;
            done     <= done_n;
            busy     <= (state_n != IDLE);
            in_ready <= (state_n == IDLE);
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: even, odd and no-parity builds
// share one clock and reset.
module tb_serial_tx;

    logic       clk;
    logic       rst;
    logic [7:0] d [3];
    logic [2:0] v;
    logic [2:0] r, txo, bz, dn;
    int         checks;
    int         errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(d[0]), .in_valid(v[0]),
        .in_ready(r[0]), .tx(txo[0]), .busy(bz[0]), .done(dn[0])
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(d[1]), .in_valid(v[1]),
        .in_ready(r[1]), .tx(txo[1]), .busy(bz[1]), .done(dn[1])
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
        .clk(clk), .rst(rst), .in_data(d[2]), .in_valid(v[2]),
        .in_ready(r[2]), .tx(txo[2]), .busy(bz[2]), .done(dn[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic hs(input int k, input logic [7:0] data);
        @(negedge clk);
        d[k] = data;
        v[k] = 1'b1;
        chk("ready_hs", 32'(r[k]), 32'd1);
        @(posedge clk);
        #1;
        v[k] = 1'b0;
        d[k] = 'x;
    endtask

    // Checks every cycle of a frame after its handshake edge, then the done cycle.
    task automatic body(input int k, input logic [7:0] data, input int npar,
                        input logic pbit, input int pulse);
        logic [10:0] bits;
        int nb;
        nb = 10 + npar;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = data;
        if (npar != 0) bits[9] = pbit;
        for (int i = 0; i < nb * 4; i++) begin
            @(negedge clk);
            chk($sformatf("tx%0d_c%0d", k, i + 1), 32'(txo[k]), 32'(bits[i / 4]));
            chk("busy", 32'(bz[k]), 32'd1);
            chk("done_early", 32'(dn[k]), 32'd0);
            if (pulse != 0 && i == 10) begin
                v[k] = 1'b1;
                d[k] = 8'hC3;
            end
            if (pulse != 0 && i == 11) begin
                chk("ready_busy", 32'(r[k]), 32'd0);
                v[k] = 1'b0;
                d[k] = 'x;
            end
        end
        @(negedge clk);
        chk("done", 32'(dn[k]), 32'd1);
        chk("tx_gap", 32'(txo[k]), 32'd1);
        chk("ready_done", 32'(r[k]), 32'd1);
        chk("busy_done", 32'(bz[k]), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        v = 3'b111;
        for (int k = 0; k < 3; k++) d[k] = 8'hFF;

        // Reset holds the line idle and ignores a pending word.
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", 32'(txo), 32'h7);
            chk("rst_busy", 32'(bz), 32'h0);
            chk("rst_done", 32'(dn), 32'h0);
            chk("rst_ready", 32'(r), 32'h0);
        end
        v = 3'b000;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(r), 32'h7);
        chk("idle_after_rst", 32'(bz), 32'h0);

        // A5, even parity: 0 | 1,0,1,0,0,1,0,1 | 0 | 1
        hs(0, 8'hA5);
        body(0, 8'hA5, 1, 1'b0, 0);
        @(negedge clk);
        chk("done_once", 32'(dn[0]), 32'd0);

        // 01, odd parity: parity bit 0
        hs(1, 8'h01);
        body(1, 8'h01, 1, 1'b0, 0);

        // No parity slot: 40 active cycles
        hs(2, 8'hA5);
        body(2, 8'hA5, 0, 1'b0, 0);

        // Back-to-back: FF accepted in the done cycle of 00
        hs(0, 8'h00);
        v[0] = 1'b1;
        d[0] = 8'hFF;
        body(0, 8'h00, 1, 1'b0, 0);
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        d[0] = 'x;
        body(0, 8'hFF, 1, 1'b0, 0);

        // C3 pulsed while busy must be dropped
        hs(0, 8'h3C);
        body(0, 8'h3C, 1, 1'b0, 1);
        repeat (4) begin
            @(negedge clk);
            chk("ignored_busy", 32'(bz[0]), 32'd0);
            chk("ignored_tx", 32'(txo[0]), 32'd1);
        end

        // Reset during data bit 3 of 55
        hs(0, 8'h55);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("pre_rst_tx", 32'(txo[0]), (i < 4) ? 32'd0 : 32'((i / 4 - 1) % 2 == 0));
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", 32'(txo[0]), 32'd1);
        chk("midrst_busy", 32'(bz[0]), 32'd0);
        chk("midrst_done", 32'(dn[0]), 32'd0);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_done", 32'(dn[0]), 32'd0);
            chk("post_rst_tx", 32'(txo[0]), 32'd1);
        end
        hs(0, 8'h55);
        body(0, 8'h55, 1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
